// File: rtl/psc_sequencer.sv
// Round-robin sequencer that shares a PSC block array among NUM_REQ requesters.
// Optional WAIT watchdog enabled by defining PSC_SEQ_TIMEOUT_EN.
module psc_sequencer #(
    parameter int unsigned NUM_REQ        = 2,
    parameter int unsigned TIMEOUT_CYCLES = 255,
    localparam int unsigned IDW           = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NUM_REQ-1:0]   req_valid,
    input  logic [2*NUM_REQ-1:0] req_mode,
    output logic [NUM_REQ-1:0]   req_ready,
    output logic [NUM_REQ-1:0]   req_done,
    output logic [NUM_REQ-1:0]   req_err,
    output logic [1:0]           psc_mode,
    output logic                 psc_start,
    input  logic                 psc_finish,
    output logic                 busy,
    output logic [IDW-1:0]       grant_id
);

    localparam int unsigned WDW = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } state_t;

    if (NUM_REQ < 2 || NUM_REQ > 8 || TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_param
        $error("psc_sequencer: parameter out of range");
    end

    state_t               state_q, state_d;
    logic [1:0]           mode_q, mode_d;
    logic [IDW-1:0]       ptr_q, ptr_d;
    logic [IDW-1:0]       owner_d;
    logic [NUM_REQ-1:0]   owner_oh;
    logic                 err_d;
    logic                 timeout_c;

    logic                 found;
    logic [IDW-1:0]       pick;
    logic [IDW-1:0]       idx;
    logic [1:0]           mode_sel;

    // Round-robin search starting at the pointer (last grant + 1).
    always_comb begin
        found = 1'b0;
        pick  = '0;
        idx   = '0;
        for (int k = 0; k < int'(NUM_REQ); k++) begin
            idx = IDW'((int'(ptr_q) + k) % int'(NUM_REQ));
            if (!found && req_valid[idx]) begin
                found = 1'b1;
                pick  = idx;
            end
        end
    end

    assign mode_sel = req_mode[{pick, 1'b0} +: 2];

`ifdef PSC_SEQ_TIMEOUT_EN
    logic [WDW-1:0] wdog_q;

    // Counts cycles spent in WAIT; cleared in every other state.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wdog_q <= '0;
        end else if (state_q == WAIT) begin
            wdog_q <= wdog_q + 1'b1;
        end else begin
            wdog_q <= '0;
        end
    end

    assign timeout_c = (state_q == WAIT) && (wdog_q == WDW'(TIMEOUT_CYCLES - 1));
`else
    assign timeout_c = 1'b0;
`endif

    // Next-state logic; req_ready is the grant decision of the IDLE cycle itself.
    always_comb begin
        state_d   = state_q;
        mode_d    = mode_q;
        ptr_d     = ptr_q;
        owner_d   = grant_id;
        err_d     = 1'b0;
        req_ready = '0;
        case (state_q)
            IDLE: begin
                if (found && reset) begin
                    req_ready[pick] = 1'b1;
                    mode_d          = mode_sel;
                    owner_d         = pick;
                    ptr_d           = (pick == IDW'(NUM_REQ - 1)) ? '0 : IDW'(pick + 1'b1);
                    state_d         = (mode_sel == 2'b00) ? DONE : START;
                end
            end
            START: state_d = WAIT;
            WAIT: begin
                if (psc_finish) begin
                    state_d = DONE;
                end else if (timeout_c) begin
                    state_d = DONE;
                    err_d   = 1'b1;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        owner_oh          = '0;
        owner_oh[owner_d] = 1'b1;
    end

    // State and registered outputs, computed from the next state.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            mode_q    <= 2'b00;
            ptr_q     <= '0;
            grant_id  <= '0;
            psc_start <= 1'b0;
            psc_mode  <= 2'b00;
            busy      <= 1'b0;
            req_done  <= '0;
            req_err   <= '0;
        end else begin
            state_q   <= state_d;
            mode_q    <= mode_d;
            ptr_q     <= ptr_d;
            grant_id  <= owner_d;
            psc_start <= (state_d == START);
            psc_mode  <= (state_d == IDLE) ? 2'b00 : mode_d;
            busy      <= (state_d != IDLE);
            req_done  <= (state_d == DONE) ? owner_oh : '0;
            req_err   <= err_d ? owner_oh : '0;
        end
    end

endmodule

// File: tb/tb_psc_sequencer.sv
// Directed bench for psc_sequencer (NUM_REQ=2, TIMEOUT_CYCLES=4): vector table plus corner sequences.
module tb_psc_sequencer;

    localparam int unsigned TO = 4;

    logic       clk = 1'b0;
    logic       reset;
    logic [1:0] req_valid;
    logic [3:0] req_mode;
    logic [1:0] req_ready, req_done, req_err;
    logic [1:0] psc_mode;
    logic       psc_start, psc_finish, busy;
    logic [0:0] grant_id;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    psc_sequencer #(.NUM_REQ(2), .TIMEOUT_CYCLES(TO)) dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_mode   (req_mode),
        .req_ready  (req_ready),
        .req_done   (req_done),
        .req_err    (req_err),
        .psc_mode   (psc_mode),
        .psc_start  (psc_start),
        .psc_finish (psc_finish),
        .busy       (busy),
        .grant_id   (grant_id)
    );

    typedef struct {
        logic [1:0]  v;
        logic [3:0]  m;
        logic        f;
        logic [10:0] exp;
    } vec_t;

    vec_t vecs[$];

    function automatic logic [10:0] e(input logic [1:0] rdy, input logic [1:0] done, input logic [1:0] err,
                                      input logic st, input logic [1:0] pm, input logic b, input logic g);
        return {rdy, done, err, st, pm, b, g};
    endfunction

    function automatic logic [10:0] outs();
        return {req_ready, req_done, req_err, psc_start, psc_mode, busy, grant_id};
    endfunction

    function automatic void add(input logic [1:0] v, input logic [3:0] m, input logic f,
                                input logic [1:0] rdy, input logic [1:0] done, input logic st,
                                input logic [1:0] pm, input logic b, input logic g);
        vec_t r;
        r.v = v; r.m = m; r.f = f;
        r.exp = e(rdy, done, 2'b00, st, pm, b, g);
        vecs.push_back(r);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step(input logic [1:0] v, input logic [3:0] m, input logic f);
        @(negedge clk);
        req_valid  = v;
        req_mode   = m;
        psc_finish = f;
        #1;
    endtask

    int seen_done;
    logic o;
    logic prev_gid;
    logic [1:0] pmx;
    logic [1:0] ohx;

    initial begin
        reset = 1'b0; req_valid = 2'b11; req_mode = 4'b0101; psc_finish = 1'b1;
        repeat (3) @(negedge clk);
        #1 chk("reset_vals", 32'(outs()), 32'(e(0, 0, 0, 0, 0, 0, 0)));
        @(negedge clk);
        req_valid = 2'b00; psc_finish = 1'b0;
        reset = 1'b1;

        // Basic transaction: grant 0, start next cycle, finish at cycle 5, done at 6.
        add(2'b01, 4'b0101, 0, 2'b01, 2'b00, 0, 2'b00, 0, 0);
        add(2'b00, 4'b0101, 0, 2'b00, 2'b00, 1, 2'b01, 1, 0);
        add(2'b00, 4'b0101, 0, 2'b00, 2'b00, 0, 2'b01, 1, 0);
        add(2'b00, 4'b0101, 0, 2'b00, 2'b00, 0, 2'b01, 1, 0);
        add(2'b00, 4'b0101, 0, 2'b00, 2'b00, 0, 2'b01, 1, 0);
        add(2'b00, 4'b0101, 1, 2'b00, 2'b00, 0, 2'b01, 1, 0);
        add(2'b00, 4'b0101, 0, 2'b00, 2'b01, 0, 2'b01, 1, 0);
        // No-op mode for requester 1: ready, then done one cycle later, no start.
        add(2'b10, 4'b0001, 0, 2'b10, 2'b00, 0, 2'b00, 0, 0);
        add(2'b00, 4'b0001, 0, 2'b00, 2'b10, 0, 2'b00, 1, 1);
        add(2'b00, 4'b0001, 0, 2'b00, 2'b00, 0, 2'b00, 0, 1);
        // Both requesting: alternating grants 0,1,0,1 with finish 3 cycles after start.
        prev_gid = 1'b1;
        for (int g = 0; g < 4; g++) begin
            o   = (g % 2 == 1);
            pmx = o ? 2'b11 : 2'b10;
            ohx = o ? 2'b10 : 2'b01;
            add(2'b11, 4'b1110, 0, ohx,   2'b00, 0, 2'b00, 0, prev_gid);
            add(2'b11, 4'b1110, 0, 2'b00, 2'b00, 1, pmx,   1, o);
            add(2'b11, 4'b1110, 0, 2'b00, 2'b00, 0, pmx,   1, o);
            add(2'b11, 4'b1110, 0, 2'b00, 2'b00, 0, pmx,   1, o);
            add(2'b11, 4'b1110, 1, 2'b00, 2'b00, 0, pmx,   1, o);
            add(2'b11, 4'b1110, 0, 2'b00, ohx,   0, pmx,   1, o);
            prev_gid = o;
        end
        add(2'b00, 4'b1110, 0, 2'b00, 2'b00, 0, 2'b00, 0, 1);

        foreach (vecs[i]) begin
            step(vecs[i].v, vecs[i].m, vecs[i].f);
            chk($sformatf("vec%0d", i), 32'(outs()), 32'(vecs[i].exp));
        end

        // Finish pulses in IDLE and START are ignored.
        step(2'b00, 4'b0001, 1); chk("fin_idle",   32'(outs()), 32'(e(0, 0, 0, 0, 2'b00, 0, 1)));
        step(2'b01, 4'b0001, 1); chk("fin_grant",  32'(outs()), 32'(e(2'b01, 0, 0, 0, 2'b00, 0, 1)));
        step(2'b00, 4'b0001, 1); chk("fin_start",  32'(outs()), 32'(e(0, 0, 0, 1, 2'b01, 1, 0)));
        step(2'b00, 4'b0001, 0); chk("fin_wait0",  32'(outs()), 32'(e(0, 0, 0, 0, 2'b01, 1, 0)));
        step(2'b00, 4'b0001, 1); chk("fin_wait1",  32'(outs()), 32'(e(0, 0, 0, 0, 2'b01, 1, 0)));
        step(2'b00, 4'b0001, 0); chk("fin_done",   32'(outs()), 32'(e(0, 2'b01, 0, 0, 2'b01, 1, 0)));
        step(2'b00, 4'b0001, 0); chk("fin_idle2",  32'(outs()), 32'(e(0, 0, 0, 0, 2'b00, 0, 0)));

        // Lone requester 1 re-granted back-to-back (no-op mode).
        step(2'b10, 4'b0001, 0); chk("lone_g1",    32'(outs()), 32'(e(2'b10, 0, 0, 0, 2'b00, 0, 0)));
        step(2'b10, 4'b0001, 0); chk("lone_d1",    32'(outs()), 32'(e(0, 2'b10, 0, 0, 2'b00, 1, 1)));
        step(2'b10, 4'b0001, 0); chk("lone_g2",    32'(outs()), 32'(e(2'b10, 0, 0, 0, 2'b00, 0, 1)));
        step(2'b00, 4'b0001, 0); chk("lone_d2",    32'(outs()), 32'(e(0, 2'b10, 0, 0, 2'b00, 1, 1)));

        // Watchdog behaviour with no finish.
        step(2'b01, 4'b0001, 0); chk("to_grant",   32'(outs()), 32'(e(2'b01, 0, 0, 0, 2'b00, 0, 1)));
        step(2'b00, 4'b0001, 0); chk("to_start",   32'(outs()), 32'(e(0, 0, 0, 1, 2'b01, 1, 0)));
`ifdef PSC_SEQ_TIMEOUT_EN
        for (int i = 0; i < int'(TO); i++) begin
            step(2'b00, 4'b0001, 0);
            chk($sformatf("to_wait%0d", i), 32'(outs()), 32'(e(0, 0, 0, 0, 2'b01, 1, 0)));
        end
        step(2'b00, 4'b0001, 0); chk("to_done",    32'(outs()), 32'(e(0, 2'b01, 2'b01, 0, 2'b01, 1, 0)));
        step(2'b00, 4'b0001, 0); chk("to_idle",    32'(outs()), 32'(e(0, 0, 0, 0, 2'b00, 0, 0)));
        step(2'b01, 4'b0001, 0); chk("rs_grant",   32'(outs()), 32'(e(2'b01, 0, 0, 0, 2'b00, 0, 0)));
        step(2'b00, 4'b0001, 0);
        step(2'b00, 4'b0001, 0); chk("rs_wait",    32'(outs()), 32'(e(0, 0, 0, 0, 2'b01, 1, 0)));
`else
        seen_done = 0;
        for (int i = 0; i < 300; i++) begin
            step(2'b00, 4'b0001, 0);
            if (req_done != 2'b00) seen_done++;
        end
        chk("no_to_done", 32'(seen_done), 32'd0);
        chk("no_to_busy", 32'(outs()), 32'(e(0, 0, 0, 0, 2'b01, 1, 0)));
`endif

        // Reset mid-WAIT aborts at once; requester 0 wins first afterwards.
        @(negedge clk);
        req_valid = 2'b11; req_mode = 4'b0001; psc_finish = 1'b0;
        #2 reset = 1'b0;
        #1 chk("rst_abort", 32'(outs()), 32'(e(0, 0, 0, 0, 2'b00, 0, 0)));
        @(negedge clk);
        #1 chk("rst_hold",  32'(outs()), 32'(e(0, 0, 0, 0, 2'b00, 0, 0)));
        reset = 1'b1;
        #1 chk("rst_grant", 32'(outs()), 32'(e(2'b01, 0, 0, 0, 2'b00, 0, 0)));
        step(2'b10, 4'b0001, 0); chk("rst_start", 32'(outs()), 32'(e(0, 0, 0, 1, 2'b01, 1, 0)));
        step(2'b10, 4'b0001, 1); chk("rst_wait",  32'(outs()), 32'(e(0, 0, 0, 0, 2'b01, 1, 0)));
        step(2'b00, 4'b0001, 0); chk("rst_done",  32'(outs()), 32'(e(0, 2'b01, 0, 0, 2'b01, 1, 0)));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
